// File: rtl/wb_regfile.sv
// Write-back stage register file: 31 x 32-bit registers (r0 hardwired to zero),
// two decode read ports with write-first bypass, an unbypassed debug port and a saturating commit counter.
module wb_regfile #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      DataMemDW,
  input  logic [31:0]      ALUResW,
  input  logic [4:0]       RegWriteAddrW,
  input  logic             MemtoRegW,
  input  logic             RegWriteW,
  input  logic [4:0]       ReadAddr1D,
  input  logic [4:0]       ReadAddr2D,
  output logic [31:0]      ReadData1D,
  output logic [31:0]      ReadData2D,
  output logic [31:0]      ResultW,
  input  logic [4:0]       DbgAddr,
  output logic [31:0]      DbgData,
  output logic [CNT_W-1:0] WbCount
);

  logic [31:0]      regs_q [1:31];
  logic [CNT_W-1:0] wb_count_q, wb_count_d;
  logic             write_en;
  logic [31:0]      stored1, stored2, stored_dbg;

  assign ResultW  = MemtoRegW ? DataMemDW : ALUResW;
  assign write_en = !rst && RegWriteW && (RegWriteAddrW != 5'd0);

  // Index 0 has no storage: only 1..31 are decoded, so it falls through to zero.
  always_comb begin
    stored1    = '0;
    stored2    = '0;
    stored_dbg = '0;
    for (int i = 1; i < 32; i++) begin
      if (ReadAddr1D == 5'(i)) stored1    = regs_q[i];
      if (ReadAddr2D == 5'(i)) stored2    = regs_q[i];
      if (DbgAddr    == 5'(i)) stored_dbg = regs_q[i];
    end
  end

  // write_en already excludes r0 and reset, so a matching address is never index 0.
  assign ReadData1D = (write_en && ReadAddr1D == RegWriteAddrW) ? ResultW : stored1;
  assign ReadData2D = (write_en && ReadAddr2D == RegWriteAddrW) ? ResultW : stored2;
  assign DbgData    = stored_dbg;

  always_comb begin
    wb_count_d = wb_count_q;
    if (write_en && wb_count_q != '1) wb_count_d = wb_count_q + CNT_W'(1);
  end

  // NOTE: the register array is reset along with the counter because a reset must
  // make every read return 0; this forces flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
      wb_count_q <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (write_en && RegWriteAddrW == 5'(i)) regs_q[i] <= ResultW;
      end
      wb_count_q <= wb_count_d;
    end
  end

  assign WbCount = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: bypass, r0, reset priority, back-to-back writes,
// and counter saturation on a second CNT_W=4 instance that shares the same stimulus.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] DataMemDW, ALUResW;
  logic [4:0]  RegWriteAddrW, ReadAddr1D, ReadAddr2D, DbgAddr;
  logic        MemtoRegW, RegWriteW;

  logic [31:0] rd1, rd2, res, dbg;
  logic [15:0] cnt;
  logic [31:0] rd1_4, rd2_4, res_4, dbg_4;
  logic [3:0]  cnt_4;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  wb_regfile #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .DataMemDW(DataMemDW), .ALUResW(ALUResW),
    .RegWriteAddrW(RegWriteAddrW), .MemtoRegW(MemtoRegW), .RegWriteW(RegWriteW),
    .ReadAddr1D(ReadAddr1D), .ReadAddr2D(ReadAddr2D), .ReadData1D(rd1),
    .ReadData2D(rd2), .ResultW(res), .DbgAddr(DbgAddr), .DbgData(dbg), .WbCount(cnt)
  );

  wb_regfile #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .DataMemDW(DataMemDW), .ALUResW(ALUResW),
    .RegWriteAddrW(RegWriteAddrW), .MemtoRegW(MemtoRegW), .RegWriteW(RegWriteW),
    .ReadAddr1D(ReadAddr1D), .ReadAddr2D(ReadAddr2D), .ReadData1D(rd1_4),
    .ReadData2D(rd2_4), .ResultW(res_4), .DbgAddr(DbgAddr), .DbgData(dbg_4), .WbCount(cnt_4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and are checked 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    RegWriteW = 1'b1; RegWriteAddrW = a; MemtoRegW = 1'b0; ALUResW = v;
  endtask

  initial begin
    int exp4;
    rst = 1'b1; DataMemDW = '0; ALUResW = '0; RegWriteAddrW = '0;
    MemtoRegW = 1'b0; RegWriteW = 1'b0; ReadAddr1D = '0; ReadAddr2D = '0; DbgAddr = '0;
    tick();

    // Reset held with a pending write: no bypass, result still combinational, write dropped.
    wr(5'd4, 32'h0000_AAAA); ReadAddr1D = 5'd4; ReadAddr2D = 5'd4; DbgAddr = 5'd4;
    #1;
    check("rst_no_bypass", rd1, 32'h0);
    check("rst_resultw", res, 32'h0000_AAAA);
    tick();
    rst = 1'b0; RegWriteW = 1'b0;
    #1;
    check("rst_write_dropped", dbg, 32'h0);
    check("rst_count", {16'h0, cnt}, 32'h0);

    // Write r5 from ALU.
    wr(5'd5, 32'h1234_5678);
    #1;
    check("r5_resultw", res, 32'h1234_5678);
    tick();
    RegWriteW = 1'b0; ReadAddr1D = 5'd5;
    #1;
    check("r5_read", rd1, 32'h1234_5678);
    check("r5_count", {16'h0, cnt}, 32'd1);

    // Write r7 from memory with both ports bypassing; debug sees the old value.
    RegWriteW = 1'b1; RegWriteAddrW = 5'd7; MemtoRegW = 1'b1;
    DataMemDW = 32'hDEAD_BEEF; ALUResW = 32'h0BAD_0BAD;
    ReadAddr1D = 5'd7; ReadAddr2D = 5'd7; DbgAddr = 5'd7;
    #1;
    check("r7_bypass1", rd1, 32'hDEAD_BEEF);
    check("r7_bypass2", rd2, 32'hDEAD_BEEF);
    check("r7_dbg_old", dbg, 32'h0);
    tick();
    RegWriteW = 1'b0; MemtoRegW = 1'b0;
    #1;
    check("r7_dbg_new", dbg, 32'hDEAD_BEEF);
    check("r7_count", {16'h0, cnt}, 32'd2);

    // r0 write is ignored and never bypasses.
    wr(5'd0, 32'hFFFF_FFFF); ReadAddr1D = 5'd0; ReadAddr2D = 5'd0; DbgAddr = 5'd0;
    #1;
    check("r0_same_cycle", rd1, 32'h0);
    tick();
    RegWriteW = 1'b0;
    #1;
    check("r0_after", rd2, 32'h0);
    check("r0_dbg", dbg, 32'h0);
    check("r0_count", {16'h0, cnt}, 32'd2);

    // Back-to-back writes to r9.
    wr(5'd9, 32'h1);
    tick();
    wr(5'd9, 32'h2); ReadAddr1D = 5'd9; DbgAddr = 5'd9;
    #1;
    check("r9_bypass", rd1, 32'h2);
    check("r9_dbg_mid", dbg, 32'h1);
    tick();
    RegWriteW = 1'b0; ReadAddr2D = 5'd9;
    #1;
    check("r9_final", rd2, 32'h2);
    check("r9_count", {16'h0, cnt}, 32'd4);

    // Independent bypass: only port 1 matches the destination.
    wr(5'd5, 32'h0000_0055); ReadAddr1D = 5'd5; ReadAddr2D = 5'd7;
    #1;
    check("indep_p1", rd1, 32'h0000_0055);
    check("indep_p2", rd2, 32'hDEAD_BEEF);
    tick();
    // Address match with write disabled must read storage, not ResultW.
    RegWriteW = 1'b0; RegWriteAddrW = 5'd5; ALUResW = 32'h7777_7777;
    #1;
    check("no_we_no_bypass", rd1, 32'h0000_0055);
    check("indep_count", {16'h0, cnt}, 32'd5);

    // Fill r1..r31 with their index, then reset with a write to r3 pending.
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 32'(i));
      tick();
    end
    RegWriteW = 1'b0; ReadAddr1D = 5'd3; ReadAddr2D = 5'd31; DbgAddr = 5'd17;
    #1;
    check("fill_r3", rd1, 32'd3);
    check("fill_r31", rd2, 32'd31);
    check("fill_dbg17", dbg, 32'd17);
    check("fill_count", {16'h0, cnt}, 32'd36);
    check("fill_count4_sat", {28'h0, cnt_4}, 32'd15);
    wr(5'd3, 32'h0000_0333); rst = 1'b1;
    tick();
    rst = 1'b0; RegWriteW = 1'b0;
    #1;
    check("mid_rst_r3", rd1, 32'h0);
    check("mid_rst_r31", rd2, 32'h0);
    check("mid_rst_dbg", dbg, 32'h0);
    check("mid_rst_count", {16'h0, cnt}, 32'h0);
    check("mid_rst_count4", {28'h0, cnt_4}, 32'h0);

    // Saturation: 20 effective writes, the 4-bit counter sticks at 15.
    for (int i = 0; i < 20; i++) begin
      wr(5'(1 + (i % 31)), 32'(i));
      tick();
      exp4 = (i + 1 > 15) ? 15 : i + 1;
      check($sformatf("sat4_w%0d", i + 1), {28'h0, cnt_4}, 32'(exp4));
    end
    RegWriteW = 1'b0;
    #1;
    check("sat_count16", {16'h0, cnt}, 32'd20);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter: CNT_W, 16, width of the write-back commit counter.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  one clock; reset is synchronous and active-high.
REQ-004 Port: DataMemDW  in  32  load data from the MEM/WB stage register.
REQ-005 Port: ALUResW  in  32  ALU result from the MEM/WB stage register.
REQ-006 Port: RegWriteAddrW  in  5  destination register index.
REQ-007 Port: MemtoRegW  in  1  1 selects DataMemDW as result, 0 selects ALUResW.
REQ-008 Port: RegWriteW  in  1  write enable for the destination register.
REQ-009 Port: ReadAddr1D  in  5  decode-stage read index, port 1.
REQ-010 Port: ReadAddr2D  in  5  decode-stage read index, port 2.
REQ-011 Port: ReadData1D  out  32  read data, port 1.
REQ-012 Port: ReadData2D  out  32  read data, port 2.
REQ-013 Port: ResultW  out  32  selected write-back value, for forwarding to EX.
REQ-014 Port: DbgAddr  in  5  debug read index.
REQ-015 Port: DbgData  out  32  debug read data (stored value, no bypass).
REQ-016 Port: WbCount  out  CNT_W  count of effective register writes since reset.

Function
REQ-017 ResultW SHALL be combinational: MemtoRegW ? DataMemDW : ALUResW.
REQ-018 Storage SHALL be 31 x 32-bit registers for indices 1..31; index 0 has no storage and always reads 0.
REQ-019 Effective write: rst=0, RegWriteW=1 and RegWriteAddrW!=0.
REQ-020 On an effective write, register[RegWriteAddrW] SHALL take ResultW at the rising edge; no other register changes.
REQ-021 RegWriteW=1 with RegWriteAddrW=0 SHALL change no state and SHALL not increment WbCount.
REQ-022 Read ports SHALL be combinational, with zero-cycle latency from address to data.
REQ-023 Write-first bypass: if an effective write is pending in the current cycle and ReadAddrND equals RegWriteAddrW, ReadDataND SHALL equal ResultW; otherwise it SHALL equal the stored value.
REQ-024 Both read ports SHALL bypass independently; both SHALL bypass when both addresses match.
REQ-025 Reads of index 0 SHALL return 0 regardless of RegWriteW, RegWriteAddrW or ResultW.
REQ-026 While rst=1, the bypass SHALL be disabled and the read ports SHALL return stored values.
REQ-027 DbgData SHALL return the stored value of register[DbgAddr] (0 for index 0) and SHALL never bypass.
REQ-028 WbCount SHALL increment by 1 on each effective write.
REQ-029 WbCount SHALL saturate at 2^CNT_W-1 and SHALL not wrap.
REQ-030 Writes SHALL be accepted every cycle with no stall; back-to-back writes to the same index SHALL leave the last value written.

Reset
REQ-031 On a rising edge with rst=1, all 31 registers SHALL clear to 0 and WbCount SHALL clear to 0.
REQ-032 A write presented in the same cycle as rst=1 SHALL be dropped and SHALL not be counted.
REQ-033 Reset asserted mid-sequence SHALL take priority over any pending write; ReadData1D, ReadData2D and DbgData SHALL read 0 from the cycle after reset.
REQ-034 ResultW SHALL stay purely combinational and unaffected by rst.

Verification
REQ-035 Reset, then write r5 with ALUResW=0x1234_5678, MemtoRegW=0, RegWriteW=1 -> next cycle ReadData1D(addr 5)=0x12345678 and WbCount=1.
REQ-036 Same cycle: write r7 with DataMemDW=0xDEAD_BEEF, MemtoRegW=1, and ReadAddr1D=ReadAddr2D=7 -> both ReadData outputs=0xDEADBEEF in that cycle; DbgData(7)=old value until the edge.
REQ-037 Write r0 with 0xFFFF_FFFF -> ReadData1D(addr 0)=0 in the same cycle and afterwards; WbCount unchanged.
REQ-038 Fill r1..r31 with their index values, assert rst for one cycle while a write to r3 is pending -> all reads return 0 and WbCount=0 after the reset edge.
REQ-039 With CNT_W=4, perform 20 effective writes -> WbCount=15 from the 15th write onward.
REQ-040 Write r9=0x1 then r9=0x2 on consecutive cycles -> r9 reads 0x2 afterwards and WbCount increases by 2.
